// File: rtl/msi_bus_pkg.sv
// Shared definitions for the MSI snoop bus.
// Contents: bus-word opcode encodings, bit positions of the word fields,
// the bus_arbiter state type, and a helper that advances the 1..3
// round-robin pointer.
package msi_bus_pkg;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_RDMISS = 2'b01;
  localparam logic [1:0] OP_WRMISS = 2'b10;
  localparam logic [1:0] OP_INV    = 2'b11;

  localparam int WB_BIT = 7;
  localparam int OP_HI  = 5;
  localparam int OP_LO  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_MEM = 2'd2,
    REPLY    = 2'd3
  } state_e;

  // Cache indices are 1..3. The index after 3 wraps back to 1.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'd3) ? 2'd1 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker.
// Ports:
//   req [2:0] : request lines; bit k-1 belongs to cache k.
//   ptr [1:0] : highest-priority cache index, 1..3.
//   gnt [2:0] : one-hot winner, or 000 when nothing is requested.
//   idx [1:0] : winner index 1..3, or 0 when nothing is requested.
// Candidates are searched in the order ptr, ptr+1, ptr+2, wrapping within 1..3.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] idx
);

  function automatic logic [1:0] wrap_add(input logic [1:0] p, input logic [1:0] o);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, o};
    if (s > 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  logic [1:0] w_cand;

  // Walk from the lowest priority to the highest, so the highest-priority
  // requester overwrites any earlier hit.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    w_cand = '0;
    for (int off = 2; off >= 0; off--) begin
      w_cand = wrap_add(ptr, 2'(off));
      if (req[w_cand - 2'd1]) begin
        gnt                = '0;
        gnt[w_cand - 2'd1] = 1'b1;
        idx                = w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared MSI snoop bus.
// Grants the bus to one cache controller at a time. It holds ownership
// across a read miss or write miss until the memory reply has been
// broadcast, or until the memory times out.
// Ports:
//   Clock, Reset      : clock; synchronous active-high reset.
//   Barramento1..3    : bus words from caches 1..3.
//   BarramentoMemoria : memory reply word.
//   BusWire           : registered broadcast word.
//   Grant             : one-hot current owner; bit k-1 is cache k.
//   Busy              : arbiter is inside a transaction.
//   BusError          : one-cycle pulse when memory fails to reply in time.
// All outputs are registered from the current state, so they show what
// that state drives one clock after the state was entered.
module bus_arbiter
  import msi_bus_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Barramento1,
  input  logic [WIDTH-1:0] Barramento2,
  input  logic [WIDTH-1:0] Barramento3,
  input  logic [WIDTH-1:0] BarramentoMemoria,
  output logic [WIDTH-1:0] BusWire,
  output logic [2:0]       Grant,
  output logic             Busy,
  output logic             BusError
);

  function automatic logic is_req(input logic [WIDTH-1:0] w);
    return w[WB_BIT] | (w[OP_HI:OP_LO] != OP_NONE);
  endfunction

  function automatic logic is_miss(input logic [WIDTH-1:0] w);
    return (w[OP_HI:OP_LO] == OP_RDMISS) || (w[OP_HI:OP_LO] == OP_WRMISS);
  endfunction

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [2:0]       r_owner;
  logic [1:0]       r_owner_idx;
  logic [WIDTH-1:0] r_txn, r_mem;

  logic [2:0]       w_req, w_pick_gnt;
  logic [1:0]       w_pick_idx;
  logic [WIDTH-1:0] w_word, w_bus;
  logic [2:0]       w_grant;
  logic             w_err, w_latch_txn, w_latch_mem;

  assign w_req = {is_req(Barramento3), is_req(Barramento2), is_req(Barramento1)};

  rr_pick3 u_pick (
    .req (w_req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx)
  );

  always_comb begin
    case (w_pick_idx)
      2'd1:    w_word = Barramento1;
      2'd2:    w_word = Barramento2;
      default: w_word = Barramento3;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_latch_txn = 1'b0;
    w_latch_mem = 1'b0;
    w_bus       = '0;
    w_grant     = (r_state != IDLE) ? r_owner : 3'b000;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_latch_txn = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_bus = r_txn;
        if (is_miss(r_txn)) begin
          w_state_nxt = WAIT_MEM;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = next_ptr(r_owner_idx);
        end
      end
      WAIT_MEM: begin
        // A reply on the final counter cycle takes priority over the timeout.
        if (BarramentoMemoria[OP_HI:OP_LO] != OP_NONE) begin
          w_latch_mem = 1'b1;
          w_state_nxt = REPLY;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
          w_ptr_nxt   = next_ptr(r_owner_idx);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      REPLY: begin
        w_bus       = r_mem;
        w_state_nxt = IDLE;
        w_ptr_nxt   = next_ptr(r_owner_idx);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers. A reset during a transaction abandons it
  // without raising BusError.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd1;
      r_cnt       <= '0;
      r_owner     <= '0;
      r_owner_idx <= 2'd1;
      BusWire     <= '0;
      Grant       <= '0;
      Busy        <= 1'b0;
      BusError    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      BusWire  <= w_bus;
      Grant    <= w_grant;
      Busy     <= (r_state != IDLE);
      BusError <= w_err;
      if (w_latch_txn) begin
        r_owner     <= w_pick_gnt;
        r_owner_idx <= w_pick_idx;
      end
    end
  end

  // Transaction and reply data latches.
  always_ff @(posedge Clock) begin
    if (w_latch_txn) r_txn <= w_word;
    if (w_latch_mem) r_mem <= BarramentoMemoria;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int WIDTH   = 11;
  localparam int TIMEOUT = 16;

  localparam logic [10:0] INV1 = 11'h031;
  localparam logic [10:0] INV2 = 11'h430;
  localparam logic [10:0] INV3 = 11'h7B0;
  localparam logic [10:0] RD1  = 11'h215;
  localparam logic [10:0] RD2  = 11'h610;
  localparam logic [10:0] WR1  = 11'h120;
  localparam logic [10:0] WR3  = 11'h0A0;
  localparam logic [10:0] WB3  = 11'h080;
  localparam logic [10:0] MEMW = 11'h59A;
  localparam logic [10:0] MEMX = 11'h020;
  localparam logic [10:0] Z    = 11'h000;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] B1, B2, B3, BM;
  logic [WIDTH-1:0] BusWire;
  logic [2:0]       Grant;
  logic             Busy, BusError;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  bus_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock             (Clock),
    .Reset             (Reset),
    .Barramento1       (B1),
    .Barramento2       (B2),
    .Barramento3       (B3),
    .BarramentoMemoria (BM),
    .BusWire           (BusWire),
    .Grant             (Grant),
    .Busy              (Busy),
    .BusError          (BusError)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic [10:0] b1, b2, b3, mem;
    logic [10:0] bus;
    logic [2:0]  gnt;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string tag, input logic rst,
                              input logic [10:0] b1, input logic [10:0] b2,
                              input logic [10:0] b3, input logic [10:0] mem,
                              input logic [10:0] bus, input logic [2:0] gnt,
                              input logic busy, input logic err);
    vec_t v;
    v.tag = tag; v.rst = rst; v.b1 = b1; v.b2 = b2; v.b3 = b3; v.mem = mem;
    v.bus = bus; v.gnt = gnt; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, then sample 1 time unit later.
  task automatic step(input vec_t v);
    Reset = v.rst; B1 = v.b1; B2 = v.b2; B3 = v.b3; BM = v.mem;
    @(posedge Clock);
    #1;
    chk({v.tag, ".BusWire"},  32'(BusWire),  32'(v.bus));
    chk({v.tag, ".Grant"},    32'(Grant),    32'(v.gnt));
    chk({v.tag, ".Busy"},     32'(Busy),     32'(v.busy));
    chk({v.tag, ".BusError"}, 32'(BusError), 32'(v.err));
  endtask

  initial begin
    Reset = 1'b1; B1 = Z; B2 = Z; B3 = Z; BM = Z;

    // Single invalidate from cache 2, then the pointer must sit at 3.
    tbl.push_back(mk("rst0",   1, Z,    Z,    Z,    Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("inv2_a", 0, Z,    INV2, Z,    Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("inv2_b", 0, Z,    Z,    Z,    Z, INV2, 3'b010, 1, 0));
    tbl.push_back(mk("inv2_c", 0, Z,    Z,    Z,    Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("ptr3_a", 0, INV1, Z,    INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("ptr3_b", 0, INV1, Z,    INV3, Z, INV3, 3'b100, 1, 0));
    tbl.push_back(mk("ptr1_a", 0, INV1, Z,    INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("ptr1_b", 0, INV1, Z,    INV3, Z, INV1, 3'b001, 1, 0));
    tbl.push_back(mk("ptr1_c", 0, Z,    Z,    Z,    Z, Z,    3'b000, 0, 0));
    // All three invalidating continuously: order 1,2,3,1.
    tbl.push_back(mk("rr_rst", 1, INV1, INV2, INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("rr_1a",  0, INV1, INV2, INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("rr_1b",  0, INV1, INV2, INV3, Z, INV1, 3'b001, 1, 0));
    tbl.push_back(mk("rr_2a",  0, INV1, INV2, INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("rr_2b",  0, INV1, INV2, INV3, Z, INV2, 3'b010, 1, 0));
    tbl.push_back(mk("rr_3a",  0, INV1, INV2, INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("rr_3b",  0, INV1, INV2, INV3, Z, INV3, 3'b100, 1, 0));
    tbl.push_back(mk("rr_4a",  0, INV1, INV2, INV3, Z, Z,    3'b000, 0, 0));
    tbl.push_back(mk("rr_4b",  0, INV1, INV2, INV3, Z, INV1, 3'b001, 1, 0));
    // Cache 1 read miss. A valid memory word during GRANT is ignored,
    // and the reply arrives on the fifth WAIT_MEM edge.
    tbl.push_back(mk("rd_rst", 1, Z,    Z,    Z,    Z,    Z,    3'b000, 0, 0));
    tbl.push_back(mk("rd_req", 0, RD1,  Z,    Z,    Z,    Z,    3'b000, 0, 0));
    tbl.push_back(mk("rd_gnt", 0, Z,    Z,    Z,    MEMX, RD1,  3'b001, 1, 0));
    tbl.push_back(mk("rd_w1",  0, Z,    Z,    Z,    Z,    Z,    3'b001, 1, 0));
    tbl.push_back(mk("rd_w2",  0, Z,    Z,    Z,    Z,    Z,    3'b001, 1, 0));
    tbl.push_back(mk("rd_w3",  0, Z,    Z,    Z,    Z,    Z,    3'b001, 1, 0));
    tbl.push_back(mk("rd_w4",  0, Z,    Z,    Z,    Z,    Z,    3'b001, 1, 0));
    tbl.push_back(mk("rd_w5",  0, Z,    Z,    Z,    MEMW, Z,    3'b001, 1, 0));
    tbl.push_back(mk("rd_rep", 0, Z,    Z,    Z,    Z,    MEMW, 3'b001, 1, 0));
    tbl.push_back(mk("rd_end", 0, Z,    Z,    Z,    Z,    Z,    3'b000, 0, 0));
    // Write-back-only request from cache 3 completes without a memory wait.
    tbl.push_back(mk("wb_a",   0, Z,    Z,    WB3,  Z,    Z,    3'b000, 0, 0));
    tbl.push_back(mk("wb_b",   0, Z,    Z,    Z,    Z,    WB3,  3'b100, 1, 0));
    tbl.push_back(mk("wb_c",   0, Z,    Z,    Z,    Z,    Z,    3'b000, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Cache 3 write miss with silent memory: timeout.
    step(mk("to_rst", 1, Z, Z, Z,   Z, Z,   3'b000, 0, 0));
    step(mk("to_req", 0, Z, Z, WR3, Z, Z,   3'b000, 0, 0));
    step(mk("to_gnt", 0, Z, Z, Z,   Z, WR3, 3'b100, 1, 0));
    for (int i = 0; i < TIMEOUT - 1; i++)
      step(mk($sformatf("to_w%0d", i), 0, Z, Z, Z, Z, Z, 3'b100, 1, 0));
    step(mk("to_err",  0, INV1, INV2, Z, Z, Z,    3'b100, 1, 1));
    step(mk("to_idle", 0, INV1, INV2, Z, Z, Z,    3'b000, 0, 0));
    step(mk("to_next", 0, Z,    Z,    Z, Z, INV1, 3'b001, 1, 0));
    step(mk("to_done", 0, Z,    Z,    Z, Z, Z,    3'b000, 0, 0));

    // Reply arriving on the final counter cycle wins over the timeout.
    step(mk("late_rst", 1, Z, Z,   Z, Z, Z,   3'b000, 0, 0));
    step(mk("late_req", 0, Z, RD2, Z, Z, Z,   3'b000, 0, 0));
    step(mk("late_gnt", 0, Z, Z,   Z, Z, RD2, 3'b010, 1, 0));
    for (int i = 0; i < TIMEOUT - 1; i++)
      step(mk($sformatf("late_w%0d", i), 0, Z, Z, Z, Z, Z, 3'b010, 1, 0));
    step(mk("late_hit", 0, Z, Z, Z, MEMW, Z,    3'b010, 1, 0));
    step(mk("late_rep", 0, Z, Z, Z, Z,    MEMW, 3'b010, 1, 0));
    step(mk("late_end", 0, Z, Z, Z, Z,    Z,    3'b000, 0, 0));

    // Reset during WAIT_MEM: everything clears, the stale reply is ignored,
    // and the pointer is back at 1.
    step(mk("mr_rst",   1, Z,    Z, Z,    Z,    Z,    3'b000, 0, 0));
    step(mk("mr_req",   0, WR1,  Z, Z,    Z,    Z,    3'b000, 0, 0));
    step(mk("mr_gnt",   0, Z,    Z, Z,    Z,    WR1,  3'b001, 1, 0));
    step(mk("mr_wait",  0, Z,    Z, Z,    Z,    Z,    3'b001, 1, 0));
    step(mk("mr_reset", 1, Z,    Z, Z,    MEMW, Z,    3'b000, 0, 0));
    step(mk("mr_stale", 0, Z,    Z, Z,    MEMW, Z,    3'b000, 0, 0));
    step(mk("mr_quiet", 0, Z,    Z, Z,    MEMW, Z,    3'b000, 0, 0));
    step(mk("mr_pick",  0, INV1, Z, INV3, Z,    Z,    3'b000, 0, 0));
    step(mk("mr_ptr1",  0, Z,    Z, Z,    Z,    INV1, 3'b001, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequential arbiter and sequencer for the shared snoop bus of the MSI coherence system. Accepts bus words from the three cache controllers, grants the bus to one at a time in round-robin order, and broadcasts the granted word. Holds the bus until the memory reply for read or write misses has been broadcast. Replaces priority-fixed combinational bus muxing with fair, transaction-atomic bus ownership.

## Interface
Parameters:
- WIDTH, 11: bus word width.
- TIMEOUT, 16: maximum number of WAIT_MEM cycles allowed before a transaction is aborted.
- CW, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- Clock  input  1  sole clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Barramento1  input  WIDTH  bus word from cache 1.
- Barramento2  input  WIDTH  bus word from cache 2.
- Barramento3  input  WIDTH  bus word from cache 3.
- BarramentoMemoria  input  WIDTH  reply word from memory.
- BusWire  output  WIDTH  registered broadcast word seen by all snoopers.
- Grant  output  3  one-hot owner of the bus; bit k-1 is cache k.
- Busy  output  1  high whenever the state is not IDLE.
- BusError  output  1  one-cycle pulse on a memory timeout.

## Operation
Word fields:
- Bit 7 = write-back flag.
- Bits 5:4 = op: 00 none, 01 read miss, 10 write miss, 11 invalidate.
- All other bits pass through unchanged.
- Cache k requests when bit7==1 or op!=00.
- A memory reply is valid when BarramentoMemoria[5:4]!=00.

Round-robin pointer:
- Pointer ptr ∈ {1,2,3}, reset to 1.
- Search order is ptr, ptr+1, ptr+2 (mod 3, values 1..3).
- After a transaction ends (normally or by timeout), ptr becomes winner+1 mod 3.

State machine:
- IDLE:
  - If any request is present: select the winner, latch the winner's word into txn, load Grant, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - BusWire = txn for exactly one cycle.
  - If txn op ∈ {01,10}: go to WAIT_MEM and clear the counter.
  - Otherwise (invalidate, or write-back only): go to IDLE, clear Grant, rotate ptr.
- WAIT_MEM:
  - BusWire = 0 and Grant is held.
  - If a valid memory reply is present: latch it and go to REPLY.
  - Else if counter == TIMEOUT-1: pulse BusError, clear Grant, rotate ptr, go to IDLE.
  - Otherwise increment the counter.
- REPLY:
  - BusWire = latched memory word for one cycle, Grant held.
  - Then go to IDLE, clear Grant, rotate ptr.

Boundary rules:
- Requester words are sampled only in IDLE; changes or deassertion after the latch are ignored.
- Memory words outside WAIT_MEM are ignored.
- A reply arriving on the timeout cycle wins; BusError is not pulsed.
- Simultaneous requests are resolved solely by ptr.
- Reset mid-transaction abandons it immediately with no BusError.

## Timing
- Reset values: BusWire=0, Grant=000, Busy=0, BusError=0, state IDLE, ptr=1, counter=0.
- All outputs are registered.
- Request-to-broadcast latency: 1 cycle (request sampled at edge n, BusWire valid after edge n+1).
- Transaction with no reply: 2 cycles (IDLE, GRANT); back-to-back grants occur every 2 cycles.
- Miss transaction: reply sampled at edge m, broadcast after edge m+1, Grant drops after edge m+2.
- Grant is stable and one-hot for the whole transaction.
- BusWire is 0 whenever the state is IDLE or WAIT_MEM.

## Structure
- Shared package msi_bus_pkg holds:
  - op encodings: OP_NONE, OP_RDMISS, OP_WRMISS, OP_INV;
  - bit positions: WB_BIT=7, OP_HI=5, OP_LO=4;
  - state enum: IDLE, GRANT, WAIT_MEM, REPLY.
- One sub-module, rr_pick3:
  - combinational;
  - inputs: req[2:0] and ptr;
  - outputs: one-hot winner and its index.
- FSM, latches and counter live in bus_arbiter.

## Test plan
- Reset, then cache 2 drives op 11 (invalidate): Grant=010 and BusWire=word1 one cycle later; back to IDLE after 2 cycles; ptr=3.
- All three caches request invalidate continuously: grant order 1,2,3,1, each granted exactly once per 6 cycles.
- Cache 1 read miss (op 01); memory replies op 01 after 5 cycles: Grant=001 held throughout; BusWire=0 during wait; reply broadcast one cycle after sampling; no BusError.
- Cache 3 write miss; memory stays silent: BusError pulses after TIMEOUT cycles in WAIT_MEM; Grant clears; next request from cache 1 is granted.
- Reply arrives on the last counter cycle: REPLY is taken, BusError stays 0.
- Reset asserted during WAIT_MEM: next cycle all outputs are 0, ptr=1, and the stale memory word is ignored.
